// File: rtl/csa_resolve_89.sv
// Carry-propagate resolver for a carry-save pair: sums c+s over several
// cycles, CHUNK bits per cycle, with valid/ready on both sides.
module csa_resolve_89 #(
  parameter int unsigned W     = 89,
  parameter int unsigned CHUNK = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] s_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int unsigned LASTW  = W - (NCHUNK - 1) * CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [W:0]    ONE_SH = (W+1)'(1) << CHUNK;
  localparam logic [W-1:0]  MASK   = W'(ONE_SH - (W+1)'(1));
  localparam logic [KW-1:0] KLAST  = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state, state_nx;
  logic [W-1:0]      c_reg, s_reg;
  logic [KW-1:0]     k;
  logic              carry;
  logic              load, step_en, last;
  int unsigned       shamt;
  logic [CHUNK-1:0]  sl_c, sl_s;
  logic [CHUNK:0]    slice_sum;
  logic              carry_nx;
  logic [W-1:0]      sum_merged;

  // Slice datapath: the narrow last slice carries out at bit LASTW, not CHUNK.
  always_comb begin
    shamt      = 32'(k) * CHUNK;
    last       = (k == KLAST);
    sl_c       = CHUNK'(c_reg >> shamt);
    sl_s       = CHUNK'(s_reg >> shamt);
    slice_sum  = (CHUNK+1)'(sl_c) + (CHUNK+1)'(sl_s) + (CHUNK+1)'(carry);
    carry_nx   = last ? slice_sum[LASTW] : slice_sum[CHUNK];
    sum_merged = (sum & ~(MASK << shamt)) | (W'(slice_sum[CHUNK-1:0]) << shamt);
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step_en  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = ADD;
          load     = 1'b1;
        end
      end
      ADD: begin
        step_en = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      c_reg     <= '0;
      s_reg     <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx == DONE);
      if (load) begin
        c_reg <= c_in;
        s_reg <= s_in;
        k     <= '0;
        carry <= 1'b0;
      end
      if (step_en) begin
        sum   <= sum_merged;
        carry <= carry_nx;
        k     <= last ? '0 : k + KW'(1);
        if (last) cout <= carry_nx;
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_89.sv
// Bench for csa_resolve_89: directed cases plus random pairs against c+s,
// and a CHUNK sweep (1, 29, 89) sharing the same operands.
module tb_csa_resolve_89;
  localparam int unsigned W = 89;
  localparam int unsigned NCH = 3;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] c_in, s_in, sum;

  logic         sw_valid;
  logic         sw_ir [3];
  logic         sw_ov [3];
  logic         sw_co [3];
  logic [W-1:0] sw_sum [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csa_resolve_89 #(.W(W), .CHUNK(30)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c_in(c_in), .s_in(s_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout));

  csa_resolve_89 #(.W(W), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[0]),
    .c_in(c_in), .s_in(s_in), .out_valid(sw_ov[0]), .out_ready(1'b1),
    .sum(sw_sum[0]), .cout(sw_co[0]));

  csa_resolve_89 #(.W(W), .CHUNK(29)) u_c29 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[1]),
    .c_in(c_in), .s_in(s_in), .out_valid(sw_ov[1]), .out_ready(1'b1),
    .sum(sw_sum[1]), .cout(sw_co[1]));

  csa_resolve_89 #(.W(W), .CHUNK(89)) u_c89 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[2]),
    .c_in(c_in), .s_in(s_in), .out_valid(sw_ov[2]), .out_ready(1'b1),
    .sum(sw_sum[2]), .cout(sw_co[2]));

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return '1;
      1: return W'(r) | (W'(1) << $urandom_range(0, W - 1));
      default: return W'(r);
    endcase
  endfunction

  // One transaction on the main DUT; stall = cycles out_ready is held low in DONE.
  task automatic do_op(input logic [W-1:0] c, input logic [W-1:0] s, input int stall);
    logic [W:0] exp;
    logic [W:0] held;
    int lat;
    int guard;
    exp = {1'b0, c} + {1'b0, s};
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    chk("in_ready_before_op", {{W{1'b0}}, in_ready}, (W+1)'(1));
    out_ready = (stall == 0);
    in_valid = 1'b1; c_in = c; s_in = s;
    step();
    in_valid = 1'b0; c_in = rnd_w(); s_in = rnd_w();
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_busy", {{W{1'b0}}, in_ready}, '0);
      c_in = rnd_w(); s_in = rnd_w();
      step(); lat++;
    end
    chk("latency", (W+1)'(lat), (W+1)'(NCH));
    chk("result", {cout, sum}, exp);
    held = {cout, sum};
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", {{W{1'b0}}, out_valid}, (W+1)'(1));
      chk("stall_hold", {cout, sum}, held);
      chk("stall_in_ready", {{W{1'b0}}, in_ready}, '0);
    end
    out_ready = 1'b1;
    step();
    chk("out_valid_drop", {{W{1'b0}}, out_valid}, '0);
    chk("in_ready_back", {{W{1'b0}}, in_ready}, (W+1)'(1));
  endtask

  // One transaction on the three CHUNK-sweep instances in parallel.
  task automatic sw_op(input logic [W-1:0] c, input logic [W-1:0] s);
    logic [W:0] exp;
    bit seen [3];
    int cyc;
    exp = {1'b0, c} + {1'b0, s};
    seen = '{default: 1'b0};
    in_valid = 1'b0;
    c_in = c; s_in = s; sw_valid = 1'b1;
    step();
    sw_valid = 1'b0; c_in = rnd_w(); s_in = rnd_w();
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2]) && cyc < 120) begin
      for (int i = 0; i < 3; i++) begin
        if (sw_ov[i] && !seen[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("sweep%0d_result", i), {sw_co[i], sw_sum[i]}, exp);
        end
      end
      step(); cyc++;
    end
    chk("sweep_timeout", (W+1)'(seen[0] && seen[1] && seen[2]), (W+1)'(1));
    chk("sweep_idle", (W+1)'(sw_ir[0] && sw_ir[1] && sw_ir[2]), (W+1)'(1));
  endtask

  initial begin
    logic [W-1:0] one_w;
    one_w = W'(1);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sw_valid = 1'b0;
    c_in = '0; s_in = '0;
    step(); step();
    chk("rst_in_ready", {{W{1'b0}}, in_ready}, '0);
    chk("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
    chk("rst_result", {cout, sum}, '0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", {{W{1'b0}}, in_ready}, (W+1)'(1));

    do_op('0, '0, 0);
    do_op(one_w, '1, 0);
    do_op((one_w << 30) - W'(2), W'(2), 0);
    do_op((one_w << 60) - W'(1), W'(1), 0);
    do_op(W'(5), W'(7), 5);
    do_op('1, '1, 2);

    // Reset in the middle of ADD abandons the operation.
    in_valid = 1'b1; c_in = W'(3); s_in = W'(4);
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_in_ready", {{W{1'b0}}, in_ready}, '0);
    chk("midrst_out_valid", {{W{1'b0}}, out_valid}, '0);
    chk("midrst_result", {cout, sum}, '0);
    rst_n = 1'b1;
    step();
    chk("midrst_idle", {{W{1'b0}}, in_ready}, (W+1)'(1));
    step();
    chk("midrst_no_output", {{W{1'b0}}, out_valid}, '0);
    do_op(W'(10), W'(20), 0);

    for (int n = 0; n < 1000; n++) begin
      do_op(rnd_w(), rnd_w(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      if ($urandom_range(0, 3) == 0) step();
    end

    sw_op(one_w, '1);
    sw_op('1, '1);
    sw_op((one_w << 29) - W'(1), W'(1));
    for (int n = 0; n < 60; n++) sw_op(rnd_w(), rnd_w());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
